// File: rtl/pe_array_sched_pkg.sv
// Shared types for the PE array command scheduler: FSM states and the command word.
package pe_types;

    localparam int unsigned SCHED_MAX_CHAINS = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_MAX_CHAINS-1:0] chain_mask;
        logic                        feature_valid;
        logic                        flush;
        logic                        send;
    } sched_cmd_t;

endpackage

// File: rtl/pe_array_sched_result_fifo.sv
// Synchronous result FIFO with occupancy count and a registered head-of-queue output.
module sched_result_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW-1:0]        rd_ptr_next_s;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] remain_s;
    logic [WIDTH-1:0]     head_r;

    // Entries left after this cycle's pop decide where the next head comes from.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r + AW'(rd_en);
        remain_s      = count_r - CNT_WIDTH'(rd_en);
    end

    // Storage array; written only, never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, count and head register; a write into an emptying FIFO bypasses the array.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(wr_en);
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_r + CNT_WIDTH'(wr_en) - CNT_WIDTH'(rd_en);
            if (remain_s != '0) begin
                head_r <= mem_r[rd_ptr_next_s];
            end else if (wr_en) begin
                head_r <= wr_data;
            end else begin
                head_r <= head_r;
            end
        end
    end

    assign rd_data = head_r;
    assign count   = count_r;

endmodule

// File: rtl/pe_array_sched.sv
// PE array command scheduler: credit-gated command issue, per-chain pulses, result buffering.
module pe_array_sched
    import pe_types::*;
#(
    parameter int NUM_CHAINS   = 4,
    parameter int RESULT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [NUM_CHAINS-1:0]              i_chain_mask,
    input  logic                               i_feature_valid,
    input  logic                               i_flush,
    input  logic                               i_send,
    output logic [NUM_CHAINS-1:0]              o_feature_valid,
    output logic [NUM_CHAINS-1:0]              o_flush,
    output logic [NUM_CHAINS-1:0]              o_send,
    input  logic                               i_result_valid,
    input  logic [NUM_CHAINS*RESULT_WIDTH-1:0] i_result,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [NUM_CHAINS*RESULT_WIDTH-1:0] o_data,
    input  logic                               i_quiesce,
    output logic                               o_idle,
    output logic                               o_overflow,
    output logic                               o_protocol_err
);

    localparam int DW = NUM_CHAINS * RESULT_WIDTH;
    localparam logic [CNT_WIDTH:0] DEPTH_C = (CNT_WIDTH + 1)'(FIFO_DEPTH);

    sched_cmd_t           cmd_s;
    sched_state_t         state_r;
    logic                 ready_r;
    logic [NUM_CHAINS-1:0] mask_s;
    logic                 any_s;
    logic                 acc_s, inc_s, dec_s, pop_s, push_s, full_s, empty_s;
    logic                 credit_next_s, drained_s;
    logic [CNT_WIDTH-1:0] count_s, count_next_s, inflight_r, inflight_next_s;
    logic [NUM_CHAINS-1:0] feat_r, flush_r, send_r;
    logic                 ovf_r, perr_r;
    logic [DW-1:0]        head_s;

    // Pack the command inputs into the shared command word.
    always_comb begin
        cmd_s.chain_mask    = SCHED_MAX_CHAINS'(i_chain_mask);
        cmd_s.feature_valid = i_feature_valid;
        cmd_s.flush         = i_flush;
        cmd_s.send          = i_send;
        mask_s              = cmd_s.chain_mask[NUM_CHAINS-1:0];
        any_s               = |cmd_s.chain_mask;
    end

    assign acc_s = i_valid && ready_r;

    // Credit accounting; in-flight saturates at zero so stray results cannot wrap it.
    always_comb begin
        inc_s           = acc_s && cmd_s.send && any_s;
        empty_s         = (count_s == '0);
        full_s          = (count_s == CNT_WIDTH'(FIFO_DEPTH));
        pop_s           = !empty_s && i_ready;
        push_s          = i_result_valid && (!full_s || pop_s);
        dec_s           = i_result_valid && ((inflight_r != '0) || inc_s);
        count_next_s    = count_s + CNT_WIDTH'(push_s) - CNT_WIDTH'(pop_s);
        inflight_next_s = inflight_r + CNT_WIDTH'(inc_s) - CNT_WIDTH'(dec_s);
        credit_next_s   = ({1'b0, count_next_s} + {1'b0, inflight_next_s}) < DEPTH_C;
        drained_s       = (inflight_r == '0) && empty_s;
    end

    // Run/drain/idle FSM; ready is registered from next-cycle credit so it is 0 in reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= RUN;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (i_quiesce) begin
                        state_r <= DRAIN;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= RUN;
                        ready_r <= credit_next_s;
                    end
                end
                DRAIN: begin
                    if (!i_quiesce) begin
                        state_r <= RUN;
                        ready_r <= credit_next_s;
                    end else if (drained_s) begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= DRAIN;
                        ready_r <= 1'b0;
                    end
                end
                IDLE: begin
                    if (!i_quiesce) begin
                        state_r <= RUN;
                        ready_r <= credit_next_s;
                    end else begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= RUN;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // In-flight counter and sticky error flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight_r <= '0;
            ovf_r      <= 1'b0;
            perr_r     <= 1'b0;
        end else begin
            inflight_r <= inflight_next_s;
            ovf_r      <= ovf_r | (i_result_valid && full_s && !pop_s);
            perr_r     <= perr_r | (i_result_valid && (inflight_r == '0) && !inc_s);
        end
    end

    // One-cycle per-chain control pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            feat_r  <= '0;
            flush_r <= '0;
            send_r  <= '0;
        end else if (acc_s) begin
            feat_r  <= mask_s & {NUM_CHAINS{cmd_s.feature_valid}};
            flush_r <= mask_s & {NUM_CHAINS{cmd_s.flush}};
            send_r  <= mask_s & {NUM_CHAINS{cmd_s.send}};
        end else begin
            feat_r  <= '0;
            flush_r <= '0;
            send_r  <= '0;
        end
    end

    sched_result_fifo #(
        .WIDTH    (DW),
        .DEPTH    (FIFO_DEPTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .wr_en  (push_s),
        .wr_data(i_result),
        .rd_en  (pop_s),
        .rd_data(head_s),
        .count  (count_s)
    );

    assign o_ready         = ready_r;
    assign o_feature_valid = feat_r;
    assign o_flush         = flush_r;
    assign o_send          = send_r;
    assign o_valid         = !empty_s;
    assign o_data          = head_s;
    assign o_idle          = (state_r == IDLE);
    assign o_overflow      = ovf_r;
    assign o_protocol_err  = perr_r;

endmodule
